// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: shared cache configuration type and a default configuration
// sized for a two-entry miss tracker.
package snitch_icache_pkg;

    typedef struct packed {
        int unsigned FETCH_AW;
        int unsigned ID_WIDTH;
        int unsigned SET_COUNT;
        int unsigned SET_ALIGN;
        int unsigned LINE_WIDTH;
        int unsigned LINE_ALIGN;
        int unsigned COUNT_ALIGN;
        int unsigned TAG_WIDTH;
        int unsigned PENDING_COUNT;
        int unsigned PENDING_IW;
    } config_t;

    localparam config_t DEFAULT_CFG = '{
        FETCH_AW: 32, ID_WIDTH: 2, SET_COUNT: 2, SET_ALIGN: 1, LINE_WIDTH: 32,
        LINE_ALIGN: 5, COUNT_ALIGN: 5, TAG_WIDTH: 22, PENDING_COUNT: 2, PENDING_IW: 1
    };

endpackage

// File: rtl/lzc.sv
// lzc: trailing (MODE=0) or leading (MODE=1) zero counter; empty_o flags an all-zero input.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--)
            if (in_i[MODE ? int'(WIDTH) - 1 - i : i]) cnt_o = CNT_WIDTH'(i);
        empty_o = ~|in_i;
    end

endmodule

// File: rtl/snitch_icache_miss_tracker.sv
// snitch_icache_miss_tracker: answers lookup hits, coalesces misses per cache line,
// issues refills and forwards refill data to the requester and the lookup write port.
module snitch_icache_miss_tracker
    import snitch_icache_pkg::*;
#(
    parameter config_t CFG = DEFAULT_CFG
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [CFG.FETCH_AW-1:0]       in_addr_i,
    input  logic [CFG.ID_WIDTH-1:0]       in_id_i,
    input  logic [CFG.SET_ALIGN-1:0]      in_set_i,
    input  logic                          in_hit_i,
    input  logic [CFG.LINE_WIDTH-1:0]     in_data_i,
    input  logic                          in_error_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [CFG.LINE_WIDTH-1:0]     out_rsp_data_o,
    output logic                          out_rsp_error_o,
    output logic [CFG.ID_WIDTH-1:0]       out_rsp_id_o,
    output logic                          out_rsp_valid_o,
    input  logic                          out_rsp_ready_i,
    output logic [CFG.FETCH_AW-1:0]       refill_req_addr_o,
    output logic [CFG.PENDING_IW-1:0]     refill_req_id_o,
    output logic                          refill_req_valid_o,
    input  logic                          refill_req_ready_i,
    input  logic [CFG.LINE_WIDTH-1:0]     refill_rsp_data_i,
    input  logic                          refill_rsp_error_i,
    input  logic [CFG.PENDING_IW-1:0]     refill_rsp_id_i,
    input  logic                          refill_rsp_valid_i,
    output logic                          refill_rsp_ready_o,
    output logic [CFG.COUNT_ALIGN-1:0]    write_addr_o,
    output logic [CFG.SET_ALIGN-1:0]      write_set_o,
    output logic [CFG.LINE_WIDTH-1:0]     write_data_o,
    output logic [CFG.TAG_WIDTH-1:0]      write_tag_o,
    output logic                          write_error_o,
    output logic                          write_valid_o,
    input  logic                          write_ready_i
);

    localparam int unsigned LINE_AW = CFG.FETCH_AW - CFG.LINE_ALIGN;
    localparam int unsigned PC      = CFG.PENDING_COUNT;
    localparam int unsigned IW      = CFG.PENDING_IW;
    localparam int unsigned SA      = CFG.SET_ALIGN;

    typedef struct packed {
        logic                    valid;
        logic                    requested;
        logic [LINE_AW-1:0]      addr;
        logic [CFG.ID_WIDTH-1:0] id;
    } entry_t;

    entry_t pending_q [PC];
    entry_t pending_d [PC];
    entry_t rsp_entry;
    logic [SA-1:0] victim_q, victim_d;
    logic [LINE_AW-1:0] in_line;
    logic [PC-1:0] match, free, unreq;
    logic [IW-1:0] match_idx, alloc_idx, req_idx;
    logic full, no_req, is_hit, is_miss, any_match, retire_match;
    logic unused_in;

    assign unused_in = ^{in_addr_i[CFG.LINE_ALIGN-1:0], in_set_i};

    always_comb begin
        match_idx = '0;
        for (int i = 0; i < int'(PC); i++) begin
            match[i] = pending_q[i].valid && pending_q[i].addr == in_line;
            free[i]  = !pending_q[i].valid;
            unreq[i] = pending_q[i].valid && !pending_q[i].requested;
            if (match[i]) match_idx = IW'(i);
        end
    end

    lzc #(.WIDTH(PC), .MODE(1'b0), .CNT_WIDTH(IW)) i_free_lzc (
        .in_i(free), .cnt_o(alloc_idx), .empty_o(full)
    );

    lzc #(.WIDTH(PC), .MODE(1'b0), .CNT_WIDTH(IW)) i_req_lzc (
        .in_i(unreq), .cnt_o(req_idx), .empty_o(no_req)
    );

    assign in_line      = in_addr_i[CFG.FETCH_AW-1:CFG.LINE_ALIGN];
    assign is_hit       = in_valid_i && in_hit_i;
    assign is_miss      = in_valid_i && !in_hit_i;
    assign any_match    = |match;
    assign rsp_entry    = pending_q[refill_rsp_id_i];
    // A miss on the line being retired rides along with that response.
    assign retire_match = is_miss && refill_rsp_valid_i && match[refill_rsp_id_i];

    assign refill_rsp_ready_o = refill_rsp_valid_i && out_rsp_ready_i && write_ready_i;
    assign in_ready_o = !in_valid_i ? 1'b1
                      : in_hit_i ? (!refill_rsp_valid_i && out_rsp_ready_i)
                      : retire_match ? refill_rsp_ready_o
                      : (any_match || !full);

    assign out_rsp_valid_o = refill_rsp_valid_i || is_hit;
    assign out_rsp_data_o  = refill_rsp_valid_i ? refill_rsp_data_i : in_data_i;
    assign out_rsp_error_o = refill_rsp_valid_i ? refill_rsp_error_i : in_error_i;
    assign out_rsp_id_o    = refill_rsp_valid_i ? (rsp_entry.id | (retire_match ? in_id_i : '0)) : in_id_i;

    assign refill_req_valid_o = !no_req;
    assign refill_req_addr_o  = {pending_q[req_idx].addr, {CFG.LINE_ALIGN{1'b0}}};
    assign refill_req_id_o    = req_idx;

    assign write_valid_o = refill_rsp_valid_i;
    assign write_addr_o  = rsp_entry.addr[CFG.COUNT_ALIGN-1:0];
    assign write_tag_o   = rsp_entry.addr[LINE_AW-1 -: CFG.TAG_WIDTH];
    assign write_data_o  = refill_rsp_data_i;
    assign write_error_o = refill_rsp_error_i;
    assign write_set_o   = victim_q;

    always_comb begin
        pending_d = pending_q;
        victim_d  = victim_q;
        if (refill_req_valid_o && refill_req_ready_i) pending_d[req_idx].requested = 1'b1;
        if (is_miss && in_ready_o && !retire_match) begin
            if (any_match) pending_d[match_idx].id = pending_q[match_idx].id | in_id_i;
            else pending_d[alloc_idx] = '{valid: 1'b1, requested: 1'b0, addr: in_line, id: in_id_i};
        end
        if (refill_rsp_ready_o) begin
            pending_d[refill_rsp_id_i] = '0;
            victim_d = (victim_q == SA'(CFG.SET_COUNT - 1)) ? '0 : victim_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '{default: '0};
            victim_q  <= '0;
        end else begin
            pending_q <= pending_d;
            victim_q  <= victim_d;
        end
    end

    refill_id_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        refill_rsp_valid_i |-> pending_q[refill_rsp_id_i].valid);

endmodule

// File: tb/tb_snitch_icache_miss_tracker.sv
// tb_snitch_icache_miss_tracker: vector table for hits, hand sequences for miss/refill
// corners; every response is checked against a scoreboard queue.
module tb_snitch_icache_miss_tracker;
    import snitch_icache_pkg::*;

    localparam config_t CFG = DEFAULT_CFG;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic [31:0] in_addr_i, in_data_i, out_rsp_data_o, refill_req_addr_o, refill_rsp_data_i, write_data_o;
    logic [1:0] in_id_i, out_rsp_id_o;
    logic [0:0] in_set_i, refill_req_id_o, refill_rsp_id_i, write_set_o;
    logic in_hit_i, in_error_i, in_valid_i, in_ready_o;
    logic out_rsp_error_o, out_rsp_valid_o, out_rsp_ready_i;
    logic refill_req_valid_o, refill_req_ready_i;
    logic refill_rsp_error_i, refill_rsp_valid_i, refill_rsp_ready_o;
    logic [4:0] write_addr_o;
    logic [21:0] write_tag_o;
    logic write_error_o, write_valid_o, write_ready_i;

    snitch_icache_miss_tracker #(.CFG(CFG)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_addr_i(in_addr_i), .in_id_i(in_id_i), .in_set_i(in_set_i), .in_hit_i(in_hit_i),
        .in_data_i(in_data_i), .in_error_i(in_error_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_rsp_data_o(out_rsp_data_o), .out_rsp_error_o(out_rsp_error_o), .out_rsp_id_o(out_rsp_id_o),
        .out_rsp_valid_o(out_rsp_valid_o), .out_rsp_ready_i(out_rsp_ready_i),
        .refill_req_addr_o(refill_req_addr_o), .refill_req_id_o(refill_req_id_o),
        .refill_req_valid_o(refill_req_valid_o), .refill_req_ready_i(refill_req_ready_i),
        .refill_rsp_data_i(refill_rsp_data_i), .refill_rsp_error_i(refill_rsp_error_i),
        .refill_rsp_id_i(refill_rsp_id_i), .refill_rsp_valid_i(refill_rsp_valid_i),
        .refill_rsp_ready_o(refill_rsp_ready_o),
        .write_addr_o(write_addr_o), .write_set_o(write_set_o), .write_data_o(write_data_o),
        .write_tag_o(write_tag_o), .write_error_o(write_error_o), .write_valid_o(write_valid_o),
        .write_ready_i(write_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [1:0]  id;
    } rsp_t;

    typedef struct {
        logic        v;
        logic        hit;
        logic [31:0] addr;
        logic [1:0]  id;
        logic [31:0] data;
        logic        rdy;
        logic        exp_valid;
        logic        exp_ready;
    } vec_t;

    rsp_t sbq[$];
    vec_t vecs[4];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic e, input logic [1:0] id);
        rsp_t r;
        r.data = d;
        r.err  = e;
        r.id   = id;
        sbq.push_back(r);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && out_rsp_valid_o && out_rsp_ready_i) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got data=%0h id=%0b, nothing expected", out_rsp_data_o, out_rsp_id_o);
            end else begin
                rsp_t e;
                e = sbq.pop_front();
                if (out_rsp_data_o !== e.data || out_rsp_error_o !== e.err || out_rsp_id_o !== e.id) begin
                    errors++;
                    $display("FAIL rsp_payload: got data=%0h err=%0b id=%0b expected data=%0h err=%0b id=%0b",
                             out_rsp_data_o, out_rsp_error_o, out_rsp_id_o, e.data, e.err, e.id);
                end
            end
        end
    end

    initial begin
        in_valid_i = 0; in_hit_i = 0; in_addr_i = 0; in_id_i = 0; in_set_i = 0;
        in_data_i = 0; in_error_i = 0; out_rsp_ready_i = 1; refill_req_ready_i = 1;
        refill_rsp_valid_i = 0; refill_rsp_id_i = 0; refill_rsp_data_i = 0;
        refill_rsp_error_i = 0; write_ready_i = 1;
        vecs = '{
            '{1'b1, 1'b1, 32'h100, 2'b01, 32'hdead0001, 1'b1, 1'b1, 1'b1},
            '{1'b1, 1'b1, 32'h2a0, 2'b10, 32'hdead0002, 1'b1, 1'b1, 1'b1},
            '{1'b1, 1'b1, 32'h100, 2'b01, 32'hdead0003, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 32'h000, 2'b00, 32'h00000000, 1'b1, 1'b0, 1'b1}
        };
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_rsp_valid_o, 0);
        check("rst_req_valid", refill_req_valid_o, 0);
        check("rst_write_valid", write_valid_o, 0);
        check("rst_refill_ready", refill_rsp_ready_o, 0);
        rst_ni = 1;
        tick();

        foreach (vecs[i]) begin
            in_valid_i = vecs[i].v; in_hit_i = vecs[i].hit; in_addr_i = vecs[i].addr;
            in_id_i = vecs[i].id; in_data_i = vecs[i].data; out_rsp_ready_i = vecs[i].rdy;
            if (vecs[i].v && vecs[i].hit && vecs[i].rdy) expect_rsp(vecs[i].data, 1'b0, vecs[i].id);
            @(negedge clk_i);
            check($sformatf("vec%0d_out_valid", i), out_rsp_valid_o, vecs[i].exp_valid);
            check($sformatf("vec%0d_in_ready", i), in_ready_o, vecs[i].exp_ready);
            tick();
        end
        in_valid_i = 0; out_rsp_ready_i = 1;

        // Two misses on one line share a single refill.
        in_valid_i = 1; in_hit_i = 0; in_addr_i = 32'h100; in_id_i = 2'b01;
        @(negedge clk_i);
        check("a_miss_ready", in_ready_o, 1);
        check("a_req_not_yet", refill_req_valid_o, 0);
        tick();
        in_addr_i = 32'h104; in_id_i = 2'b10;
        @(negedge clk_i);
        check("a_coalesce_ready", in_ready_o, 1);
        check("a_req_valid", refill_req_valid_o, 1);
        check("a_req_addr", refill_req_addr_o, 32'h100);
        check("a_req_id", refill_req_id_o, 0);
        tick();
        in_valid_i = 0;
        @(negedge clk_i);
        check("a_single_req", refill_req_valid_o, 0);
        tick();
        refill_rsp_valid_i = 1; refill_rsp_id_i = 0; refill_rsp_data_i = 32'hcafe0001;
        expect_rsp(32'hcafe0001, 1'b0, 2'b11);
        @(negedge clk_i);
        check("a_write_valid", write_valid_o, 1);
        check("a_write_addr", write_addr_o, 8);
        check("a_write_tag", write_tag_o, 0);
        check("a_write_set", write_set_o, 0);
        check("a_rsp_ready", refill_rsp_ready_o, 1);
        tick();
        refill_rsp_valid_i = 0;

        // Table full: third miss stalls until an entry retires.
        in_valid_i = 1; in_addr_i = 32'h000; in_id_i = 2'b01;
        tick();
        in_addr_i = 32'h400;
        tick();
        in_addr_i = 32'h800;
        @(negedge clk_i);
        check("b_full_stall", in_ready_o, 0);
        tick();
        tick();
        refill_rsp_valid_i = 1; refill_rsp_id_i = 0; refill_rsp_data_i = 32'hcafe0002;
        expect_rsp(32'hcafe0002, 1'b0, 2'b01);
        @(negedge clk_i);
        check("b_stall_at_retire", in_ready_o, 0);
        check("b_write_set", write_set_o, 1);
        tick();
        refill_rsp_valid_i = 0;
        @(negedge clk_i);
        check("b_ready_after_free", in_ready_o, 1);
        tick();
        in_valid_i = 0;
        @(negedge clk_i);
        check("b_req_valid", refill_req_valid_o, 1);
        check("b_req_addr", refill_req_addr_o, 32'h800);
        check("b_req_id", refill_req_id_o, 0);
        tick();
        refill_rsp_valid_i = 1; refill_rsp_id_i = 1; refill_rsp_data_i = 32'hcafe0003; refill_rsp_error_i = 1;
        expect_rsp(32'hcafe0003, 1'b1, 2'b01);
        @(negedge clk_i);
        check("b_out_error", out_rsp_error_o, 1);
        check("b_write_error", write_error_o, 1);
        check("b_write_set_wrap", write_set_o, 0);
        check("b_write_addr", write_addr_o, 0);
        check("b_write_tag", write_tag_o, 1);
        tick();
        refill_rsp_valid_i = 0; refill_rsp_error_i = 0;

        // Miss on the retiring line merges into that response.
        in_valid_i = 1; in_hit_i = 0; in_addr_i = 32'h804; in_id_i = 2'b10;
        refill_rsp_valid_i = 1; refill_rsp_id_i = 0; refill_rsp_data_i = 32'hcafe0004;
        expect_rsp(32'hcafe0004, 1'b0, 2'b11);
        @(negedge clk_i);
        check("c_merge_ready", in_ready_o, 1);
        check("c_merge_id", out_rsp_id_o, 2'b11);
        check("c_write_tag", write_tag_o, 2);
        check("c_write_set", write_set_o, 1);
        tick();
        in_valid_i = 0; refill_rsp_valid_i = 0;
        @(negedge clk_i);
        check("c_no_new_req", refill_req_valid_o, 0);
        tick();

        // Refill beats a simultaneous hit; the hit follows a cycle later.
        in_valid_i = 1; in_hit_i = 0; in_addr_i = 32'h200; in_id_i = 2'b01;
        tick();
        in_valid_i = 0;
        tick();
        tick();
        refill_rsp_valid_i = 1; refill_rsp_id_i = 0; refill_rsp_data_i = 32'hcafe0005;
        expect_rsp(32'hcafe0005, 1'b0, 2'b01);
        in_valid_i = 1; in_hit_i = 1; in_addr_i = 32'h300; in_id_i = 2'b10; in_data_i = 32'hbeef0001;
        expect_rsp(32'hbeef0001, 1'b0, 2'b10);
        @(negedge clk_i);
        check("d_hit_stalled", in_ready_o, 0);
        check("d_refill_first", out_rsp_data_o, 32'hcafe0005);
        tick();
        refill_rsp_valid_i = 0;
        @(negedge clk_i);
        check("d_hit_ready", in_ready_o, 1);
        check("d_hit_second", out_rsp_data_o, 32'hbeef0001);
        tick();
        in_valid_i = 0; in_hit_i = 0;

        // Reset drops an outstanding miss.
        refill_req_ready_i = 0;
        in_valid_i = 1; in_addr_i = 32'h600; in_id_i = 2'b01;
        tick();
        in_valid_i = 0;
        @(negedge clk_i);
        check("e_req_pending", refill_req_valid_o, 1);
        rst_ni = 0;
        #1;
        check("e_req_cleared_async", refill_req_valid_o, 0);
        tick();
        rst_ni = 1;
        tick();
        @(negedge clk_i);
        check("e_req_discarded", refill_req_valid_o, 0);
        check("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
